// File: rtl/convertor_16_to_8_if.sv
// Sample-source / UART-TX side signals of the 16-to-8 framer.
// The slave modport is the framer's view; the master modport drives writes and tx_ready.
interface convertor_16_to_8_if #(
    parameter int DEPTH = 16
);
    logic                     wr;
    logic [15:0]              data;
    logic                     tx_ready;
    logic                     tx_start;
    logic [7:0]               tx_data;
    logic                     busy;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output wr, data, tx_ready,
        input  tx_start, tx_data, busy, overflow, level
    );

    modport slave (
        input  wr, data, tx_ready,
        output tx_start, tx_data, busy, overflow, level
    );
endinterface

// File: rtl/convertor_16_to_8.sv
// Buffers 16-bit words and emits "~0_" + WORDS_PER_FRAME words (high byte first), one byte
// per 3-cycle ISSUE/GAP/POLL slot; stalls in POLL while tx_ready=0, drops writes when full.
module convertor_16_to_8 #(
    parameter int DEPTH           = 16,
    parameter int WORDS_PER_FRAME = 4
) (
    input  logic               clk,
    input  logic               rst,
    convertor_16_to_8_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int NB = 3 + 2 * WORDS_PER_FRAME;
    localparam int IW = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_POLL} state_t;

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          ovf_q;
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic [15:0]   head;
    logic          full, frame_rdy, pop, push;

    assign head      = mem_q[rd_ptr_q];
    assign full      = (level_q == LW'(DEPTH));
    assign frame_rdy = (level_q >= LW'(WORDS_PER_FRAME));
    // Payload bytes start at index 3; even indices from 4 on are low bytes.
    assign pop       = (state_q == S_ISSUE) && (idx_q >= IW'(4)) && !idx_q[0];
    assign push      = bus.wr && (!full || pop);

    function automatic logic [7:0] frame_byte(input logic [IW-1:0] idx, input logic [15:0] w);
        logic [7:0] b;
        case (idx)
            IW'(0):  b = 8'h7E;
            IW'(1):  b = 8'h30;
            IW'(2):  b = 8'h5F;
            default: b = idx[0] ? w[15:8] : w[7:0];
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);
            if (bus.wr && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (frame_rdy && bus.tx_ready) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                end
            end
            S_ISSUE: state_d = S_GAP;
            S_GAP:   state_d = S_POLL;
            S_POLL: begin
                if (bus.tx_ready) begin
                    if (idx_q == IW'(NB - 1)) begin
                        idx_d   = '0;
                        state_d = frame_rdy ? S_ISSUE : S_IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The byte is registered on entry so tx_data is valid with tx_start and then holds.
        if (state_d == S_ISSUE) begin
            tx_data_d = frame_byte(idx_d, head);
        end
    end

    assign bus.tx_start = (state_q == S_ISSUE);
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.overflow = ovf_q;
    assign bus.level    = level_q;
endmodule

// File: tb/tb_convertor_16_to_8.sv
// Bench for convertor_16_to_8: table-driven frame, directed corner sequences and a
// randomized run compared against a word-queue model of the framed byte stream.
module tb_convertor_16_to_8;
    localparam int DEPTH = 16;
    localparam int WPF   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    convertor_16_to_8_if #(.DEPTH(DEPTH)) bus ();

    convertor_16_to_8 #(.DEPTH(DEPTH), .WORDS_PER_FRAME(WPF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] w;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    vec_t        vecs [4];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_start = 0;
    bit          seen_start = 0;
    int          proto_err = 0;
    logic        rdy_edge;
    logic [7:0]  bq [$];
    int unsigned bcyc [$];
    logic [15:0] mw [$];
    logic [7:0]  exp_q [$];

    // Byte monitor: sampled 1ns after each rising edge.
    always begin
        @(posedge clk);
        cyc++;
        rdy_edge = bus.tx_ready;
        #1;
        if (bus.tx_start === 1'b1) begin
            if (rdy_edge !== 1'b1) proto_err++;
            if (seen_start && (cyc - last_start) < 3) proto_err++;
            seen_start = 1'b1;
            last_start = cyc;
            bq.push_back(bus.tx_data);
            bcyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [15:0] w);
        bus.wr   = 1'b1;
        bus.data = w;
        @(negedge clk);
        bus.wr   = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (bq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (bq.size() < n) begin
            checks++;
            errors++;
            $display("FAIL wait_bytes: got %0d bytes expected %0d", bq.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (bus.busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %0b", bus.busy);
        end
    endtask

    task automatic clear_capture();
        bq.delete();
        bcyc.delete();
        mw.delete();
    endtask

    // Model: every complete group of WPF buffered words becomes one frame.
    task automatic build_exp();
        exp_q.delete();
        for (int i = 0; i + WPF <= mw.size(); i += WPF) begin
            exp_q.push_back(8'h7E);
            exp_q.push_back(8'h30);
            exp_q.push_back(8'h5F);
            for (int j = 0; j < WPF; j++) begin
                exp_q.push_back(mw[i+j][15:8]);
                exp_q.push_back(mw[i+j][7:0]);
            end
        end
    endtask

    task automatic compare_stream(input string name);
        check({name, " length"}, bq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < bq.size(); i++) begin
            check($sformatf("%s byte %0d", name, i), {24'h0, bq[i]}, {24'h0, exp_q[i]});
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " tx_start"}, {31'h0, bus.tx_start}, 0);
        check({tag, " tx_data"},  {24'h0, bus.tx_data}, 0);
        check({tag, " busy"},     {31'h0, bus.busy}, 0);
        check({tag, " overflow"}, {31'h0, bus.overflow}, 0);
        check({tag, " level"},    {27'h0, bus.level}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned wc, t, rc;
        int busy_gaps, bad, nw, k;

        vecs[0] = '{16'h1234, 8'h12, 8'h34};
        vecs[1] = '{16'hABCD, 8'hAB, 8'hCD};
        vecs[2] = '{16'h0001, 8'h00, 8'h01};
        vecs[3] = '{16'hFF00, 8'hFF, 8'h00};

        bus.wr       = 1'b0;
        bus.data     = 16'h0;
        bus.tx_ready = 1'b1;
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single frame from the table
        clear_capture();
        wc = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) wc = cyc;
            write_word(vecs[i].w);
        end
        wait_bytes(11, 200);
        if (bq.size() >= 11) begin
            check("start latency", bcyc[0] - wc, 2);
            check("hdr0", {24'h0, bq[0]}, 32'h7E);
            check("hdr1", {24'h0, bq[1]}, 32'h30);
            check("hdr2", {24'h0, bq[2]}, 32'h5F);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("vec%0d hi", i), {24'h0, bq[3+2*i]}, {24'h0, vecs[i].hi});
                check($sformatf("vec%0d lo", i), {24'h0, bq[4+2*i]}, {24'h0, vecs[i].lo});
            end
            bad = 0;
            for (int i = 1; i < 11; i++) if (bcyc[i] - bcyc[i-1] != 3) bad++;
            check("issue spacing", bad, 0);
            t = bcyc[10];
            k = 0;
            while (cyc < t + 2 && k < 10) begin
                @(negedge clk);
                k++;
            end
            check("busy in last poll", {31'h0, bus.busy}, 1);
            @(negedge clk);
            check("busy after frame", {31'h0, bus.busy}, 0);
            check("level after frame", {27'h0, bus.level}, 0);
        end
        wait_idle(100);

        // Back-to-back frames
        clear_capture();
        for (int i = 0; i < 8; i++) begin
            mw.push_back(16'h1000 + 16'(i) * 16'h0111);
            write_word(mw[i]);
        end
        build_exp();
        wait_bytes(1, 100);
        busy_gaps = 0;
        k = 0;
        while (bq.size() < 22 && k < 200) begin
            if (bus.busy !== 1'b1) busy_gaps++;
            @(negedge clk);
            k++;
        end
        check("b2b busy gaps", busy_gaps, 0);
        compare_stream("b2b");
        if (bq.size() > 11) check("b2b second hdr", {24'h0, bq[11]}, 32'h7E);
        wait_idle(100);

        // Backpressure after the 4th byte
        clear_capture();
        for (int i = 0; i < 4; i++) begin
            mw.push_back(vecs[i].w);
            write_word(vecs[i].w);
        end
        build_exp();
        wait_bytes(4, 100);
        bus.tx_ready = 1'b0;
        repeat (50) @(negedge clk);
        check("bp no byte while stalled", bq.size(), 4);
        bus.tx_ready = 1'b1;
        rc = cyc;
        wait_bytes(11, 200);
        if (bcyc.size() > 4) check("bp resume latency", bcyc[4] - rc, 1);
        compare_stream("bp");
        wait_idle(100);

        // Overflow, then write during a pop at full
        clear_capture();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) mw.push_back(16'hC000 + 16'(i));
            write_word(16'hC000 + 16'(i));
        end
        check("ovf level full", {27'h0, bus.level}, 16);
        check("ovf flag", {31'h0, bus.overflow}, 1);
        bus.tx_ready = 1'b1;
        wait_bytes(5, 100);
        bus.wr   = 1'b1;
        bus.data = 16'hBEEF;
        @(negedge clk);
        bus.wr   = 1'b0;
        mw.push_back(16'hBEEF);
        check("push+pop at full level", {27'h0, bus.level}, 16);
        build_exp();
        wait_bytes(44, 400);
        wait_idle(100);
        compare_stream("ovf");
        check("ovf leftover level", {27'h0, bus.level}, 1);
        check("ovf sticky", {31'h0, bus.overflow}, 1);
        do_reset();
        check("reset clears overflow", {31'h0, bus.overflow}, 0);
        check("reset clears level", {27'h0, bus.level}, 0);

        // Fewer than one frame
        clear_capture();
        for (int i = 0; i < 3; i++) write_word(16'h5500 + 16'(i));
        repeat (1000) @(negedge clk);
        check("short no tx_start", bq.size(), 0);
        check("short busy", {31'h0, bus.busy}, 0);
        check("short level", {27'h0, bus.level}, 3);

        // Asynchronous reset mid-frame
        write_word(16'h5503);
        wait_bytes(5, 100);
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("midframe reset");
        @(negedge clk);
        rst = 1'b0;
        clear_capture();
        for (int i = 0; i < 3; i++) begin
            mw.push_back(16'h6600 + 16'(i));
            write_word(mw[i]);
        end
        repeat (30) @(negedge clk);
        check("post-reset no tx_start", bq.size(), 0);
        mw.push_back(16'h6603);
        write_word(16'h6603);
        build_exp();
        wait_bytes(11, 200);
        compare_stream("post-reset");
        wait_idle(100);

        // Randomized traffic with random tx_ready
        clear_capture();
        nw = 0;
        k  = 0;
        while ((nw < 24 || bq.size() < 66) && k < 6000) begin
            bus.tx_ready = ($urandom_range(0, 3) != 0);
            if (nw < 24 && $urandom_range(0, 1) == 1 && bus.level < 12) begin
                bus.wr   = 1'b1;
                bus.data = 16'($urandom);
                mw.push_back(bus.data);
                nw++;
            end else begin
                bus.wr = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.wr       = 1'b0;
        bus.tx_ready = 1'b1;
        wait_idle(100);
        build_exp();
        compare_stream("random");
        check("random final level", {27'h0, bus.level}, 0);

        check("protocol violations", proto_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
